f9pcap_tx_arbiter: RTL and testbench

Frame-granular round-robin arbiter sharing one 10G MAC TX stream between NUM_PORTS pcap-wrapped UDP sources, e.g. one f9pcap_wrap_eth per SFP RX port, each behind its own frame FIFO. It grants whole frames atomically, honours the serdes TX pause cycle, and drives a registered AXI-stream-like output with no downstream ready.

---
 rtl/f9pcap_tx_arbiter_pkg.sv | 14 +
 rtl/f9pcap_tx_arbiter_if.sv | 35 +++
 rtl/f9pcap_rr_pick.sv | 41 ++++
 rtl/f9pcap_tx_arbiter.sv | 137 +++++++++++++
 tb/tb_f9pcap_tx_arbiter.sv | 350 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/f9pcap_tx_arbiter_pkg.sv
// Shared types and helpers for the f9pcap TX arbiter: FSM state encoding and grant width.
package f9pcap_tx_arbiter_pkg;

    typedef enum logic {
        StIdle = 1'b0,
        StPass = 1'b1
    } state_e;

    // Index width for a port number; never narrower than one bit.
    function automatic int unsigned grant_width(input int unsigned num_ports);
        return (num_ports > 1) ? $clog2(num_ports) : 1;
    endfunction

endpackage

// File: rtl/f9pcap_tx_arbiter_if.sv
// Bundle of per-source request lanes, serdes pause and the shared MAC TX output stream.
interface f9pcap_tx_arbiter_if #(
    parameter int unsigned NUM_PORTS  = 2,
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned KEEP_WIDTH = DATA_WIDTH / 8
) ();
    import f9pcap_tx_arbiter_pkg::*;

    localparam int unsigned GW = grant_width(NUM_PORTS);

    logic [NUM_PORTS-1:0]            s_valid_in;
    logic [NUM_PORTS*DATA_WIDTH-1:0] s_data_in;
    logic [NUM_PORTS*KEEP_WIDTH-1:0] s_keep_in;
    logic [NUM_PORTS-1:0]            s_last_in;
    logic [NUM_PORTS-1:0]            s_ready_out;
    logic                            tx_pause_in;
    logic                            o_valid_out;
    logic [DATA_WIDTH-1:0]           o_data_out;
    logic [KEEP_WIDTH-1:0]           o_keep_out;
    logic                            o_last_out;
    logic [GW-1:0]                   grant_out;

    // Driver side: frame FIFOs plus the serdes pause, consuming the MAC stream.
    modport master (
        output s_valid_in, s_data_in, s_keep_in, s_last_in, tx_pause_in,
        input  s_ready_out, o_valid_out, o_data_out, o_keep_out, o_last_out, grant_out
    );

    // Arbiter side.
    modport slave (
        input  s_valid_in, s_data_in, s_keep_in, s_last_in, tx_pause_in,
        output s_ready_out, o_valid_out, o_data_out, o_keep_out, o_last_out, grant_out
    );

endinterface

// File: rtl/f9pcap_rr_pick.sv
// Combinational rotating-priority picker: first set request at or after ptr_i, modulo NUM_PORTS.
module f9pcap_rr_pick import f9pcap_tx_arbiter_pkg::*; #(
    parameter int unsigned NUM_PORTS = 2,
    parameter int unsigned GW        = grant_width(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] req_i,
    input  logic [GW-1:0]        ptr_i,
    output logic                 any_o,
    output logic [GW-1:0]        idx_o
);

    localparam int unsigned SW = GW + 1;
    localparam logic [SW-1:0] NumPortsW = SW'(NUM_PORTS);

    logic [NUM_PORTS-1:0] req_rot;
    logic [GW-1:0]        off;
    logic [SW-1:0]        sum;

    // Bit i of req_rot is the request of port (ptr_i + i) mod NUM_PORTS.
    assign req_rot = NUM_PORTS'({req_i, req_i} >> ptr_i);

    always_comb begin
        any_o = 1'b0;
        off   = '0;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            if (req_rot[i]) begin
                any_o = 1'b1;
                off   = GW'(i);
            end
        end
    end

    always_comb begin
        sum = {1'b0, ptr_i} + {1'b0, off};
        if (sum >= NumPortsW) begin
            sum = sum - NumPortsW;
        end
        idx_o = sum[GW-1:0];
    end

endmodule

// File: rtl/f9pcap_tx_arbiter.sv
// Frame-granular round-robin arbiter onto one registered MAC TX stream, honouring serdes pause.
// Optional per-port frame / total beat counters when F9PCAP_TX_ARB_STAT_EN is defined.
module f9pcap_tx_arbiter import f9pcap_tx_arbiter_pkg::*; #(
    parameter int unsigned NUM_PORTS  = 2,
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned KEEP_WIDTH = DATA_WIDTH / 8
) (
    input  logic                        clk_in,
    input  logic                        rst_in,
`ifdef F9PCAP_TX_ARB_STAT_EN
    output logic [NUM_PORTS*32-1:0]     stat_frames_out,
    output logic [31:0]                 stat_beats_out,
`endif
    f9pcap_tx_arbiter_if.slave          bus
);

    localparam int unsigned   GW       = grant_width(NUM_PORTS);
    localparam logic [GW-1:0] LastPort = GW'(NUM_PORTS - 1);

    state_e                 state_q, state_d;
    logic [GW-1:0]          rr_ptr_q, rr_ptr_d;
    logic [GW-1:0]          grant_q, grant_d;
    logic                   any_req;
    logic [GW-1:0]          pick;
    logic [NUM_PORTS-1:0]   ready;
    logic                   xfer, xfer_last;
    logic [DATA_WIDTH-1:0]  sel_data;
    logic [KEEP_WIDTH-1:0]  sel_keep;

    logic                   o_valid_q, o_valid_d;
    logic                   o_last_q, o_last_d;
    logic [DATA_WIDTH-1:0]  o_data_q, o_data_d;
    logic [KEEP_WIDTH-1:0]  o_keep_q, o_keep_d;

    f9pcap_rr_pick #(
        .NUM_PORTS (NUM_PORTS),
        .GW        (GW)
    ) u_pick (
        .req_i (bus.s_valid_in),
        .ptr_i (rr_ptr_q),
        .any_o (any_req),
        .idx_o (pick)
    );

    assign sel_data = bus.s_data_in[32'(grant_q) * DATA_WIDTH +: DATA_WIDTH];
    assign sel_keep = bus.s_keep_in[32'(grant_q) * KEEP_WIDTH +: KEEP_WIDTH];

    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        grant_d   = grant_q;
        ready     = '0;
        xfer      = 1'b0;
        xfer_last = 1'b0;
        case (state_q)
            StIdle: begin
                if (any_req) begin
                    grant_d = pick;
                    state_d = StPass;
                end
            end
            StPass: begin
                // Pause is combinational so the bubble lands on the gearbox's skipped cycle.
                ready[grant_q] = ~bus.tx_pause_in;
                xfer           = bus.s_valid_in[grant_q] & ~bus.tx_pause_in;
                xfer_last      = xfer & bus.s_last_in[grant_q];
                if (xfer_last) begin
                    rr_ptr_d = (grant_q == LastPort) ? '0 : grant_q + GW'(1);
                    state_d  = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        o_valid_d = xfer;
        o_last_d  = xfer_last;
        o_data_d  = xfer ? sel_data : '0;
        o_keep_d  = xfer ? sel_keep : '0;
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q   <= StIdle;
            rr_ptr_q  <= '0;
            grant_q   <= '0;
            o_valid_q <= 1'b0;
            o_last_q  <= 1'b0;
            o_data_q  <= '0;
            o_keep_q  <= '0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            grant_q   <= grant_d;
            o_valid_q <= o_valid_d;
            o_last_q  <= o_last_d;
            o_data_q  <= o_data_d;
            o_keep_q  <= o_keep_d;
        end
    end

    // No source may hand over a beat while the truncated frame is being abandoned.
    assign bus.s_ready_out = ready & {NUM_PORTS{~rst_in}};
    assign bus.o_valid_out = o_valid_q;
    assign bus.o_last_out  = o_last_q;
    assign bus.o_data_out  = o_data_q;
    assign bus.o_keep_out  = o_keep_q;
    assign bus.grant_out   = grant_q;

`ifdef F9PCAP_TX_ARB_STAT_EN
    logic [31:0] frames_q [NUM_PORTS];
    logic [31:0] beats_q;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            beats_q <= '0;
            for (int p = 0; p < NUM_PORTS; p++) begin
                frames_q[p] <= '0;
            end
        end else begin
            if (xfer) begin
                beats_q <= beats_q + 32'd1;
            end
            if (xfer_last) begin
                frames_q[grant_q] <= frames_q[grant_q] + 32'd1;
            end
        end
    end

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_stat
        assign stat_frames_out[p*32 +: 32] = frames_q[p];
    end
    assign stat_beats_out = beats_q;
`endif

endmodule

// File: tb/tb_f9pcap_tx_arbiter.sv
// Self-checking bench for f9pcap_tx_arbiter: vector table plus multi-cycle corner sequences.
module tb_f9pcap_tx_arbiter;

    localparam int unsigned NP = 2;
    localparam int unsigned DW = 64;
    localparam int unsigned KW = DW / 8;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [KW-1:0] keep;
        logic          last;
    } beat_t;

    typedef struct {
        logic [NP-1:0] req;
        int            first;
        int            second;
        logic [KW-1:0] keep;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    f9pcap_tx_arbiter_if #(.NUM_PORTS(NP), .DATA_WIDTH(DW), .KEEP_WIDTH(KW)) bus ();

`ifdef F9PCAP_TX_ARB_STAT_EN
    logic [NP*32-1:0] stat_frames;
    logic [31:0]      stat_beats;
`endif

    f9pcap_tx_arbiter #(
        .NUM_PORTS  (NP),
        .DATA_WIDTH (DW),
        .KEEP_WIDTH (KW)
    ) dut (
        .clk_in          (clk),
        .rst_in          (rst),
`ifdef F9PCAP_TX_ARB_STAT_EN
        .stat_frames_out (stat_frames),
        .stat_beats_out  (stat_beats),
`endif
        .bus             (bus)
    );

    beat_t         src_q [NP][$];
    beat_t         exp_q [$];
    logic [NP-1:0] hold;
    logic [NP-1:0] acc;
    logic          mon_en;
    logic          prev_last;
    int            n_cmp = 0;
    int            n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic beat_t make_beat(int port, int tag, int b, int n, logic [KW-1:0] lk);
        beat_t r;
        r.data = {8'(8'hA0 + port), 8'(tag), 16'(b), 32'(tag * 7919 + b * 131 + port)};
        r.keep = (b == n - 1) ? lk : '1;
        r.last = (b == n - 1);
        return r;
    endfunction

    task automatic load_src(input int port, input int tag, input int n, input logic [KW-1:0] lk);
        for (int b = 0; b < n; b++) src_q[port].push_back(make_beat(port, tag, b, n, lk));
    endtask

    task automatic expect_frame(input int port, input int tag, input int n,
                                input logic [KW-1:0] lk);
        for (int b = 0; b < n; b++) exp_q.push_back(make_beat(port, tag, b, n, lk));
    endtask

    task automatic wait_drain(input int budget, input string name);
        int i;
        i = 0;
        while (exp_q.size() != 0 && i < budget) begin
            @(negedge clk);
            i++;
        end
        chk(name, 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        repeat (2) @(negedge clk);
    endtask

    task automatic check_idle_outputs(input string name);
        chk({name, "_valid"}, 64'(bus.o_valid_out), 64'd0);
        chk({name, "_last"},  64'(bus.o_last_out),  64'd0);
        chk({name, "_keep"},  64'(bus.o_keep_out),  64'd0);
        chk({name, "_data"},  64'(bus.o_data_out),  64'd0);
        chk({name, "_ready"}, 64'(bus.s_ready_out), 64'd0);
        chk({name, "_grant"}, 64'(bus.grant_out),   64'd0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        bus.tx_pause_in = 1'b0;
        hold = '0;
        for (int p = 0; p < NP; p++) src_q[p].delete();
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Frame FIFO model: pops on an accepted beat, presents the head unless held back.
    initial begin
        bus.s_valid_in = '0;
        bus.s_data_in  = '0;
        bus.s_keep_in  = '0;
        bus.s_last_in  = '0;
        forever begin
            @(negedge clk);
            acc = bus.s_valid_in & bus.s_ready_out;
            @(posedge clk);
            #2;
            for (int p = 0; p < NP; p++) begin
                if (acc[p] && src_q[p].size() > 0) void'(src_q[p].pop_front());
                if (src_q[p].size() > 0 && !hold[p]) begin
                    bus.s_valid_in[p]         = 1'b1;
                    bus.s_data_in[p*DW +: DW] = src_q[p][0].data;
                    bus.s_keep_in[p*KW +: KW] = src_q[p][0].keep;
                    bus.s_last_in[p]          = src_q[p][0].last;
                end else begin
                    bus.s_valid_in[p]         = 1'b0;
                    bus.s_data_in[p*DW +: DW] = '0;
                    bus.s_keep_in[p*KW +: KW] = '0;
                    bus.s_last_in[p]          = 1'b0;
                end
            end
        end
    end

    // Scoreboard monitor on the output stream.
    initial begin
        beat_t e;
        prev_last = 1'b0;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (bus.o_valid_out) begin
                    chk("frame_gap", 64'(prev_last), 64'd0);
                    chk("sb_has_entry", 64'(exp_q.size() > 0), 64'd1);
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        chk("sb_data", bus.o_data_out, e.data);
                        chk("sb_keep", 64'(bus.o_keep_out), 64'(e.keep));
                        chk("sb_last", 64'(bus.o_last_out), 64'(e.last));
                    end
                end else begin
                    chk("idle_keep", 64'(bus.o_keep_out), 64'd0);
                end
                prev_last = bus.o_valid_out & bus.o_last_out;
            end else begin
                prev_last = 1'b0;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs [8];
        int   n, first0, last0, first1, v0, port;
        logic pp;

        // Expected grant order follows rr_ptr from reset: 0 -> 1 -> 1 -> 0 -> 0 -> 0 -> 1 -> 1.
        vecs[0] = '{req: 2'b01, first: 0, second: -1, keep: 8'hff};
        vecs[1] = '{req: 2'b11, first: 1, second: 0,  keep: 8'h01};
        vecs[2] = '{req: 2'b10, first: 1, second: -1, keep: 8'h3f};
        vecs[3] = '{req: 2'b11, first: 0, second: 1,  keep: 8'h0f};
        vecs[4] = '{req: 2'b10, first: 1, second: -1, keep: 8'h07};
        vecs[5] = '{req: 2'b01, first: 0, second: -1, keep: 8'h7f};
        vecs[6] = '{req: 2'b01, first: 0, second: -1, keep: 8'h03};
        vecs[7] = '{req: 2'b11, first: 1, second: 0,  keep: 8'h1f};

        bus.tx_pause_in = 1'b0;
        hold   = '0;
        mon_en = 1'b0;
        rst    = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_idle_outputs("reset");
        @(posedge clk);
        #1;
        rst    = 1'b0;
        mon_en = 1'b1;

        // Single-beat frames under varying request patterns.
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            for (int p = 0; p < NP; p++) if (vecs[i].req[p]) load_src(p, 10 + i, 1, vecs[i].keep);
            expect_frame(vecs[i].first, 10 + i, 1, vecs[i].keep);
            if (vecs[i].second >= 0) expect_frame(vecs[i].second, 10 + i, 1, vecs[i].keep);
            wait_drain(20, "tbl_drain");
            chk("tbl_grant", 64'(bus.grant_out),
                64'((vecs[i].second >= 0) ? vecs[i].second : vecs[i].first));
        end

        // Single port, 4-beat frame: latency 2, contiguous, last on beat 4.
        do_reset();
        @(negedge clk);
        load_src(0, 100, 4, 8'h0f);
        expect_frame(0, 100, 4, 8'h0f);
        n = 0;
        while (n < 8) begin
            @(negedge clk);
            if (bus.o_valid_out) break;
            n++;
        end
        chk("first_valid_latency", 64'(n), 64'd2);
        for (int b = 1; b < 4; b++) begin
            @(negedge clk);
            chk("contiguous_valid", 64'(bus.o_valid_out), 64'd1);
            chk("last_position", 64'(bus.o_last_out), 64'(b == 3));
        end
        chk("single_grant", 64'(bus.grant_out), 64'd0);
        @(negedge clk);
        chk("gap_after_last", 64'(bus.o_valid_out), 64'd0);
        wait_drain(20, "single_drain");

        // Simultaneous back-to-back frames rotate 0,1,0,1,0,1.
        do_reset();
        @(negedge clk);
        for (int f = 0; f < 3; f++) begin
            load_src(0, 200 + 2 * f, 3, 8'hff);
            load_src(1, 201 + 2 * f, 3, 8'h0f);
        end
        for (int f = 0; f < 3; f++) begin
            expect_frame(0, 200 + 2 * f, 3, 8'hff);
            expect_frame(1, 201 + 2 * f, 3, 8'h0f);
        end
        wait_drain(100, "rotate_drain");

        // 40-beat frame with 1-cycle pauses 33 cycles apart.
        do_reset();
        @(negedge clk);
        load_src(0, 250, 40, 8'hff);
        expect_frame(0, 250, 40, 8'hff);
        pp = 1'b0;
        for (int k = 0; k < 46; k++) begin
            @(posedge clk);
            #1;
            bus.tx_pause_in = (k % 33 == 3);
            @(negedge clk);
            if (k >= 2 && k <= 43) chk("pause_bubble", 64'(bus.o_valid_out), 64'(!pp));
            pp = bus.tx_pause_in;
        end
        bus.tx_pause_in = 1'b0;
        wait_drain(20, "pause_drain");

        // Atomicity: port 1 requests mid-frame while port 0 has a 2-cycle valid gap.
        do_reset();
        @(negedge clk);
        load_src(0, 300, 6, 8'h3f);
        expect_frame(0, 300, 6, 8'h3f);
        expect_frame(1, 301, 3, 8'hff);
        first0 = -1; last0 = -1; first1 = -1; v0 = 0;
        for (int k = 0; k < 30; k++) begin
            @(posedge clk);
            #1;
            if (k == 2) load_src(1, 301, 3, 8'hff);
            if (k == 3) hold[0] = 1'b1;
            if (k == 5) hold[0] = 1'b0;
            @(negedge clk);
            if (bus.o_valid_out) begin
                port = int'(bus.o_data_out[63:56]) - 'hA0;
                if (port == 0) begin
                    if (first0 < 0) first0 = k;
                    last0 = k;
                    v0++;
                end else if (first1 < 0) begin
                    first1 = k;
                end
            end
        end
        chk("atom_bubbles", 64'(last0 - first0 + 1 - v0), 64'd2);
        chk("atom_p1_after_p0", 64'(first1 > last0 + 1), 64'd1);
        wait_drain(20, "atom_drain");

        // Reset mid-frame while port 1 holds the grant and rr_ptr points at 1.
        do_reset();
        @(negedge clk);
        load_src(0, 400, 1, 8'hff);
        expect_frame(0, 400, 1, 8'hff);
        wait_drain(20, "pre_rst_drain");
        mon_en = 1'b0;
        @(negedge clk);
        load_src(1, 401, 6, 8'hff);
        @(posedge clk);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        src_q[1].delete();
        @(negedge clk);
        check_idle_outputs("rst_mid");
        repeat (3) begin
            @(negedge clk);
            chk("rst_no_tail", 64'(bus.o_valid_out | bus.o_last_out), 64'd0);
        end
        mon_en = 1'b1;
        @(negedge clk);
        load_src(0, 402, 2, 8'h01);
        load_src(1, 403, 2, 8'h03);
        expect_frame(0, 402, 2, 8'h01);
        expect_frame(1, 403, 2, 8'h03);
        wait_drain(30, "post_rst_both");
        @(negedge clk);
        load_src(1, 404, 2, 8'h07);
        expect_frame(1, 404, 2, 8'h07);
        wait_drain(20, "post_rst_p1");
        chk("post_rst_grant", 64'(bus.grant_out), 64'd1);

`ifdef F9PCAP_TX_ARB_STAT_EN
        do_reset();
        @(negedge clk);
        for (int f = 0; f < 5; f++) load_src(0, 500 + f, 4, 8'hff);
        for (int f = 0; f < 3; f++) load_src(1, 510 + f, 4, 8'hff);
        for (int f = 0; f < 3; f++) begin
            expect_frame(0, 500 + f, 4, 8'hff);
            expect_frame(1, 510 + f, 4, 8'hff);
        end
        expect_frame(0, 503, 4, 8'hff);
        expect_frame(0, 504, 4, 8'hff);
        wait_drain(200, "stat_drain");
        chk("stat_frames_p0", 64'(stat_frames[31:0]), 64'd5);
        chk("stat_frames_p1", 64'(stat_frames[63:32]), 64'd3);
        chk("stat_beats", 64'(stat_beats), 64'd32);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
